// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity helper and
// counter-width helper reused by the receive and (future) transmit blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Data narrower than 8 bits is zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calcParity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Width of an occupancy counter that must be able to hold the value 'depth' itself.
    function automatic int cntWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead circular receive FIFO with occupancy count and sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_pushData,
    input  logic                       i_pop,
    input  logic                       i_clrErr,
    output logic [DATA_W-1:0]          o_headData,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [cntWidth(DEPTH)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cntWidth(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic w_empty;
    logic w_full;
    logic w_doPop;
    logic w_doPush;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees a slot.
    assign w_doPop  = i_pop && !w_empty;
    assign w_doPush = i_push && (!w_full || w_doPop);

    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
            if (i_push && !w_doPush) begin
                r_overflow <= 1'b1;
            end else if (i_clrErr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_headData = w_empty ? '0 : r_mem[r_rdPtr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: input synchroniser, bit-timing FSM with optional
// parity and 1-2 stop bits, sticky error flags and a show-ahead receive FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            CLOCK,
    input  logic                            reset,
    input  logic                            Rx_raw,
    input  logic                            Rd_en,
    input  logic                            clr_err,
    output logic [DATA_BITS-1:0]            rx_data_out,
    output logic                            d_valid,
    output logic [cntWidth(FIFO_DEPTH)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            FE,
    output logic                            PE,
    output logic                            SFE
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

    rx_state_t r_state;
    rx_state_t w_nextState;

    logic                 r_sync1;
    logic                 r_rxS;
    logic                 r_rxPrev;
    logic [TW-1:0]        r_bitTimer;
    logic [IW-1:0]        r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parErr;
    logic                 r_push;
    logic                 r_fe;
    logic                 r_pe;
    logic                 r_sfe;

    logic w_fallEdge;
    logic w_timerZero;
    logic w_loadHalf;
    logic w_loadFull;
    logic w_sampleData;
    logic w_sampleParity;
    logic w_clrIdx;
    logic w_incIdx;
    logic w_pushSet;
    logic w_feSet;
    logic w_sfeSet;
    logic w_peSet;
    logic w_fifoEmpty;
    logic w_fifoFull;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b1;
            r_rxS    <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= Rx_raw;
            r_rxS    <= r_sync1;
            r_rxPrev <= r_rxS;
        end
    end

    assign w_fallEdge  = !r_rxS && r_rxPrev;
    assign w_timerZero = (r_bitTimer == '0);

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_loadHalf     = 1'b0;
        w_loadFull     = 1'b0;
        w_sampleData   = 1'b0;
        w_sampleParity = 1'b0;
        w_clrIdx       = 1'b0;
        w_incIdx       = 1'b0;
        w_pushSet      = 1'b0;
        w_feSet        = 1'b0;
        w_sfeSet       = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fallEdge) begin
                    w_nextState = RX_START;
                    w_loadHalf  = 1'b1;
                end
            end
            RX_START: begin
                if (w_timerZero) begin
                    if (r_rxS) begin
                        w_sfeSet    = 1'b1;
                        w_nextState = RX_IDLE;
                    end else begin
                        w_nextState = RX_DATA;
                        w_loadFull  = 1'b1;
                        w_clrIdx    = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (w_timerZero) begin
                    w_sampleData = 1'b1;
                    w_loadFull   = 1'b1;
                    // The index is reused to count stop bits, so it is cleared on the last data bit.
                    if (r_bitIdx == IW'(DATA_BITS - 1)) begin
                        w_clrIdx    = 1'b1;
                        w_nextState = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        w_incIdx = 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (w_timerZero) begin
                    w_sampleParity = 1'b1;
                    w_loadFull     = 1'b1;
                    w_nextState    = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_timerZero) begin
                    if (!r_rxS) begin
                        w_feSet     = 1'b1;
                        w_nextState = RX_IDLE;
                    end else if (r_bitIdx == IW'(STOP_BITS - 1)) begin
                        w_pushSet   = 1'b1;
                        w_nextState = RX_IDLE;
                    end else begin
                        w_incIdx   = 1'b1;
                        w_loadFull = 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_bitTimer <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_parErr   <= 1'b0;
            r_push     <= 1'b0;
        end else begin
            r_push <= w_pushSet;
            if (w_loadHalf) begin
                r_bitTimer <= HALF_LOAD;
            end else if (w_loadFull) begin
                r_bitTimer <= FULL_LOAD;
            end else if (r_state != RX_IDLE && !w_timerZero) begin
                r_bitTimer <= r_bitTimer - TW'(1);
            end
            if (w_clrIdx) begin
                r_bitIdx <= '0;
            end else if (w_incIdx) begin
                r_bitIdx <= r_bitIdx + IW'(1);
            end
            if (w_sampleData) begin
                r_shift <= {r_rxS, r_shift[DATA_BITS-1:1]};
            end
            if (w_loadHalf) begin
                r_parErr <= 1'b0;
            end else if (w_sampleParity) begin
                r_parErr <= (r_rxS != calcParity(8'(r_shift), PARITY_ODD != 0));
            end
        end
    end

    // The shift register and parity result stay stable through the push cycle,
    // since a new frame cannot reach its first data sample that quickly.
    assign w_peSet = r_push && r_parErr;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_fe  <= 1'b0;
            r_pe  <= 1'b0;
            r_sfe <= 1'b0;
        end else begin
            r_sfe <= w_sfeSet;
            if (w_feSet) begin
                r_fe <= 1'b1;
            end else if (clr_err) begin
                r_fe <= 1'b0;
            end
            if (w_peSet) begin
                r_pe <= 1'b1;
            end else if (clr_err) begin
                r_pe <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (CLOCK),
        .i_rst_n    (reset),
        .i_push     (r_push),
        .i_pushData (r_shift),
        .i_pop      (Rd_en),
        .i_clrErr   (clr_err),
        .o_headData (rx_data_out),
        .o_empty    (w_fifoEmpty),
        .o_full     (w_fifoFull),
        .o_count    (fifo_count),
        .o_overflow (overflow)
    );

    assign d_valid = !w_fifoEmpty;
    assign FE      = r_fe;
    assign PE      = r_pe;
    assign SFE     = r_sfe;

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with an integrated receive FIFO. It is the next-generation replacement for the fixed 8N1 receiver, adding configurable bit period, data width, optional parity and 1 or 2 stop bits. It also reports framing and parity errors and buffers up to `FIFO_DEPTH` characters. It sits between the raw `Rx` pin and the Forth core's I/O port, which drains it with `Rd_en`.

## Interface
- `CLKS_PER_BIT`, default 16: `CLOCK` cycles per bit. Must be ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5–8. Sent LSB first.
- `PARITY_EN`, default 0: 1 means a parity bit follows the data.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: receive FIFO depth. Must be a power of 2, ≥ 2.

Ports:
- `CLOCK` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `Rx_raw` in 1: asynchronous serial input. Idle level is high.
- `Rd_en` in 1: pops the FIFO head.
- `clr_err` in 1: one-cycle pulse that clears `overflow`, `FE` and `PE`.
- `rx_data_out` out `DATA_BITS`: FIFO head (show-ahead). Value is don't-care while `d_valid`=0.
- `d_valid` out 1: FIFO non-empty.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: number of entries.
- `overflow` out 1: sticky. A character was dropped because the FIFO was full.
- `FE` out 1: sticky framing error (a stop bit sampled low).
- `PE` out 1: sticky parity error.
- `SFE` out 1: one-cycle pulse on a false start bit.

## Operation
- **Input synchroniser.** `Rx_raw` passes through 2 flops to give `rx_s`, which resets to 1.
- **Falling-edge detection.** A falling edge is `rx_s`=0 with the previous `rx_s`=1.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge. The bit timer loads `CLKS_PER_BIT/2 - 1`.
  - START, timer at 0:
    - `rx_s`=1 → pulse `SFE`, go to IDLE.
    - `rx_s`=0 → go to DATA. Timer loads `CLKS_PER_BIT-1` and the bit index is set to 0.
  - DATA, timer at 0: shift `rx_s` into the MSB of the shift register (right shift) and increment the index. After `DATA_BITS` samples go to PARITY if `PARITY_EN`, otherwise to STOP. Every sample reloads the timer to `CLKS_PER_BIT-1`.
  - PARITY, timer at 0: compare the sampled bit with the computed parity of the data bits and latch a mismatch. Then go to STOP.
  - STOP, timer at 0, stop bit sampled low → set `FE`, discard the character, go to IDLE.
  - STOP, timer at 0, stop bit sampled high:
    - If this is the last stop bit, push the character into the FIFO and go to IDLE.
    - Otherwise stay in STOP with the timer reloaded.
  - A character with a parity mismatch is still pushed, and `PE` is set in the same cycle.
- **FIFO.** Circular buffer with pointer width `$clog2(FIFO_DEPTH)`. Pointers wrap naturally.
  - Pop when `Rd_en` && `d_valid`. `Rd_en` while empty is ignored.
  - A push while full with no simultaneous pop drops the new character and sets `overflow`. The FIFO contents are unchanged.
  - A push and a pop in the same cycle while full: both take effect and the count stays at `FIFO_DEPTH`.
  - A push and a pop in the same cycle while empty: the FIFO goes to 1 entry. The pop is ignored.
- **Error flags.**
  - `clr_err` clears all three sticky flags.
  - If a set event and `clr_err` occur in the same cycle, set wins.
- **Reset.** Applies asynchronously, including mid-frame. The FSM goes to IDLE, the timer, index and pointers go to 0, and the FIFO is emptied.
  - Output reset values: `d_valid`=0, `fifo_count`=0, `overflow`=0, `FE`=0, `PE`=0, `SFE`=0, `rx_data_out`=0.
  - After reset the receiver waits for a fresh falling edge.

## Timing
- Input latency is 2 cycles (synchroniser) plus 1 cycle (edge register).
- Start-bit verification happens `CLKS_PER_BIT/2` cycles after the edge is detected.
- Each following bit is sampled at its centre, every `CLKS_PER_BIT` cycles.
- The push occurs in the cycle after the final stop-bit sample. `d_valid` and `fifo_count` update one cycle after that.
- After a pop, `rx_data_out` shows the next entry on the cycle following `Rd_en`.
- Back-to-back frames:
  - A falling edge is accepted in the first IDLE cycle after STOP.
  - The earliest new start is half a bit after the stop-bit centre.

## Structure
- **Shared package `uart_pkg`** holds:
  - the state enum `rx_state_t`;
  - the parity-compute function;
  - a `clog2`-based width constant helper, so the future `uart_tx_param` can reuse it.
- **Sub-module `uart_rx_fifo`** is the parametrised FIFO (data width, depth) with push/pop/full/empty/count and the overflow flag.
- **Top level** contains the synchroniser, FSM, bit timer, index counter and shift register inline.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, `DATA_BITS`=8 and `FIFO_DEPTH`=4, with the parity and stop-bit settings noted per scenario.

1. **Clean frame, 8N1.** Send 0xA5 → 2 cycles after the stop-bit centre, `d_valid`=1, `rx_data_out`=0xA5 and `fifo_count`=1. Pulse `Rd_en` → `d_valid`=0.
2. **Glitch.** Drive `Rx_raw` low for 4 cycles → `SFE` pulses for exactly 1 cycle, no push, FSM back in IDLE.
3. **Low stop bit.** Send 0x3C with the stop bit low → `FE`=1 and `fifo_count` stays 0. `clr_err` → `FE`=0.
4. **Parity error.** With `PARITY_EN`=1 (even), send 0x3C with its parity bit inverted → `PE`=1 and 0x3C is pushed. A correct frame carrying 0x3C leaves `PE`=0.
5. **Overflow.** Send 0x01–0x05 without reading → `overflow`=1 and `fifo_count`=4. Reads return 0x01–0x04 in order. A push in the same cycle as a pop while full → no overflow.
6. **Reset mid-frame.** Assert `reset` low in the middle of DATA → all outputs take their reset values immediately. A following 0x55 frame (8N2) is received correctly.
